// File: rtl/snake_pkg.sv
// Shared direction encoding, debouncer state encoding and turn helpers
// for the snake game input path.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;
    localparam dir_t DIR_RESET = DIR_RIGHT;

    // Button index equals the direction code it requests.
    localparam int NUM_BTNS = 4;

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'b00,
        DB_PRESS_WAIT   = 2'b01,
        DB_PRESSED      = 2'b10,
        DB_RELEASE_WAIT = 2'b11
    } db_state_e;

    // Opposite directions differ only in bit 0.
    function automatic dir_t dir_opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM and stability counter.
// Emits a single-cycle press pulse when a press has been stable long enough.
module btn_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s1, btn_s2;
    db_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;

    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_in;
            btn_s2 <= btn_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DB_RELEASED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DB_RELEASED:     if (btn_s2) state_nxt = DB_PRESS_WAIT;
            DB_PRESS_WAIT:   if (!btn_s2) state_nxt = DB_RELEASED;
                             else if (cnt_done) state_nxt = DB_PRESSED;
            DB_PRESSED:      if (!btn_s2) state_nxt = DB_RELEASE_WAIT;
            DB_RELEASE_WAIT: if (btn_s2) state_nxt = DB_PRESSED;
                             else if (cnt_done) state_nxt = DB_RELEASED;
            default:         state_nxt = DB_RELEASED;
        endcase
    end

    // Count only while waiting out a change; any transition restarts at 0.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if ((state == DB_PRESS_WAIT || state == DB_RELEASE_WAIT) && state_nxt == state)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    always_comb begin
        press = (state == DB_PRESS_WAIT) && (state_nxt == DB_PRESSED);
    end

endmodule

// File: rtl/dir_input_ctrl.sv
// Snake input front end: debounced buttons, turn validation and per-tick release.
// TURN_QUEUE_EN selects a QUEUE_DEPTH FIFO instead of a single pending turn.
module dir_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int QUEUE_DEPTH     = 2,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       refresh,
    input  logic       up_in,
    input  logic       down_in,
    input  logic       left_in,
    input  logic       right_in,
    output logic [1:0] dir,
    output logic       step,
    output logic [1:0] queue_count,
    output logic       overflow
);

    logic [NUM_BTNS-1:0] btn_raw, btn_evt;
    logic                evt_vld;
    dir_t                evt_dir, ref_dir;
    logic                ref_s1, ref_s2, ref_s3, tick;
    logic                turn_ok, pop;

    assign btn_raw = {right_in, left_in, down_in, up_in};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn_in(btn_raw[g]),
            .press (btn_evt[g])
        );
    end

    // Lowest index wins: up > down > left > right.
    always_comb begin
        evt_vld = |btn_evt;
        evt_dir = DIR_RIGHT;
        for (int i = NUM_BTNS - 1; i >= 0; i--)
            if (btn_evt[i]) evt_dir = dir_t'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_s3 <= 1'b0;
        end else begin
            ref_s1 <= refresh;
            ref_s2 <= ref_s1;
            ref_s3 <= ref_s2;
        end
    end

    assign tick    = ref_s2 & ~ref_s3;
    assign turn_ok = evt_vld && (evt_dir != ref_dir) && (evt_dir != dir_opposite(ref_dir));

`ifdef TURN_QUEUE_EN
    localparam logic [1:0] QD = 2'(QUEUE_DEPTH);

    logic [QUEUE_DEPTH-1:0][1:0] q;
    logic [1:0]                  cnt;
    logic                        ovf, push, drop;
    int                          push_idx;

    // Head lives at q[0]; tail is q[cnt-1].
    always_comb begin
        ref_dir = dir;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (int'(cnt) == i + 1) ref_dir = q[i];
        pop      = tick && (cnt != 2'd0);
        push     = turn_ok && (cnt != QD);
        drop     = turn_ok && (cnt == QD);
        push_idx = int'(cnt) - (pop ? 1 : 0);
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            dir  <= DIR_RESET;
            step <= 1'b0;
            cnt  <= 2'd0;
            ovf  <= 1'b0;
            q    <= '0;
        end else begin
            step <= tick;
            if (pop) begin
                dir <= q[0];
                for (int i = 0; i < QUEUE_DEPTH - 1; i++)
                    q[i] <= q[i+1];
            end
            for (int i = 0; i < QUEUE_DEPTH; i++)
                if (push && i == push_idx) q[i] <= evt_dir;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    assign queue_count = cnt;
    assign overflow    = ovf;
`else
    logic pend_vld;
    dir_t pend_dir;

    always_comb begin
        ref_dir = dir;
        pop     = tick && pend_vld;
    end

    // Last valid press overwrites the pending turn, even in a tick cycle.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            dir      <= DIR_RESET;
            step     <= 1'b0;
            pend_vld <= 1'b0;
            pend_dir <= DIR_RESET;
        end else begin
            step <= tick;
            if (pop) dir <= pend_dir;
            if (turn_ok) begin
                pend_vld <= 1'b1;
                pend_dir <= evt_dir;
            end else if (pop) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign queue_count = {1'b0, pend_vld};
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl with DEBOUNCE_CYCLES=4; expectations
// follow the queue or single-pending build selected by TURN_QUEUE_EN.
module tb_dir_input_ctrl;

    logic       clk = 1'b0;
    logic       rst, restart, refresh;
    logic [3:0] btns;
    logic [1:0] dir, queue_count;
    logic       step, overflow;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    dir_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .QUEUE_DEPTH    (2),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .refresh    (refresh),
        .up_in      (btns[0]),
        .down_in    (btns[1]),
        .left_in    (btns[2]),
        .right_in   (btns[3]),
        .dir        (dir),
        .step       (step),
        .queue_count(queue_count),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks start and end on a negedge.
    task automatic hold_btns(input logic [3:0] b);
        btns = b;
        repeat (10) @(negedge clk);
        btns = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    // Refresh rises now; step/dir must appear after the 3rd posedge.
    task automatic do_tick(input string tag, input logic [1:0] exp_dir, input logic [1:0] exp_qc);
        refresh = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_step_early"}, step, 0);
        @(negedge clk);
        check({tag, "_step"}, step, 1);
        check({tag, "_dir"}, dir, exp_dir);
        check({tag, "_qc"}, queue_count, exp_qc);
        @(negedge clk);
        check({tag, "_step_pulse"}, step, 0);
        refresh = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; refresh = 1'b0; btns = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_dir", dir, 3);
        check("rst_step", step, 0);
        check("rst_qc", queue_count, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: up accepted from right, released on the tick
        hold_btns(4'b0001);
        check("t1_qc", queue_count, 1);
        do_tick("t1", 2'b00, 2'd0);

        // 2: reversal down rejected, step still pulses
        hold_btns(4'b0010);
        check("t2_qc", queue_count, 0);
        do_tick("t2", 2'b00, 2'd0);

        // 3: glitchy left never survives debounce
        btns = 4'b0100; repeat (2) @(negedge clk);
        btns = 4'b0000; @(negedge clk);
        btns = 4'b0100; repeat (2) @(negedge clk);
        btns = 4'b0000; repeat (10) @(negedge clk);
        check("t3_qc", queue_count, 0);

        // 5: up and left together from right -> only up
        do_restart();
        check("t5_dir_restart", dir, 3);
        hold_btns(4'b0101);
        check("t5_qc", queue_count, 1);
        do_tick("t5", 2'b00, 2'd0);

        // 4: up, left, down before any tick
        do_restart();
        hold_btns(4'b0001);
        hold_btns(4'b0100);
        hold_btns(4'b0010);
`ifdef TURN_QUEUE_EN
        check("t4_qc", queue_count, 2);
        check("t4_ovf", overflow, 1);
        do_tick("t4a", 2'b00, 2'd1);
        do_tick("t4b", 2'b10, 2'd0);
`else
        check("t4_qc", queue_count, 1);
        check("t4_ovf", overflow, 0);
        do_tick("t4a", 2'b01, 2'd0);
        do_tick("t4b", 2'b01, 2'd0);
`endif

        // 6: restart lands on the tick edge and wins
        do_restart();
        hold_btns(4'b0001);
        hold_btns(4'b0100);
        hold_btns(4'b0010);
`ifdef TURN_QUEUE_EN
        check("t6_ovf_pre", overflow, 1);
`else
        check("t6_qc_pre", queue_count, 1);
`endif
        refresh = 1'b1;
        repeat (2) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t6_dir", dir, 3);
        check("t6_qc", queue_count, 0);
        check("t6_ovf", overflow, 0);
        check("t6_step", step, 0);
        @(negedge clk);
        check("t6_step_after", step, 0);
        refresh = 1'b0;
        repeat (3) @(negedge clk);

        // 7: rst with a pending turn and a press mid-debounce
        hold_btns(4'b0001);
        check("t7_qc_pre", queue_count, 1);
        btns = 4'b0100;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t7_dir", dir, 3);
        check("t7_qc", queue_count, 0);
        check("t7_ovf", overflow, 0);
        check("t7_step", step, 0);
        rst = 1'b0;
        btns = 4'b0000;
        repeat (10) @(negedge clk);
        check("t7_qc_after", queue_count, 0);
        hold_btns(4'b0001);
        check("t7_press_after", queue_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
